uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one UART TX serializer among NUM_REQ independent byte sources. Each requester owns a 1-deep holding slot. The arbiter picks the next pending slot and issues it to TX as a single-cycle DATA_VALID pulse. It then tracks the TX busy_flag until the frame completes before issuing the next slot. It sits between the client logic and the TX instance and is the only driver of TX's P_DATA_from_input and DATA_VALID.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART TX among NUM_REQ byte sources, one holding slot each.
// Optional WAIT_BUSY watchdog with sticky error flag: define ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            slot_full,
    output logic [DATA_WIDTH-1:0]         tx_p_data,
    output logic                          tx_data_valid,
    input  logic                          tx_busy,
    output logic [$clog2(NUM_REQ)-1:0]    cur_id,
    output logic                          arb_busy,
    output logic                          timeout_err
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] slot_data [NUM_REQ];
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       pick;
    logic                  found;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [CW-1:0] tmo_cnt;
`endif

    // First full slot at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ)
                idx = idx - NUM_REQ;
            if (!found && slot_full[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    // A slot being issued is still full on its clearing edge, so it cannot recapture there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_full <= '0;
            req_ack   <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                slot_data[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ack[i] <= req_valid[i] && !slot_full[i];
                if (state == ISSUE && cur_id == ID_W'(i)) begin
                    slot_full[i] <= 1'b0;
                end else if (req_valid[i] && !slot_full[i]) begin
                    slot_full[i] <= 1'b1;
                    slot_data[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            cur_id        <= '0;
            tx_p_data     <= '0;
            tx_data_valid <= 1'b0;
            arb_busy      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt       <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            tx_data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state         <= ISSUE;
                        cur_id        <= pick;
                        tx_p_data     <= slot_data[pick];
                        tx_data_valid <= 1'b1;
                        arb_busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    state  <= WAIT_BUSY;
                    rr_ptr <= (cur_id == ID_W'(NUM_REQ-1)) ? '0 : cur_id + 1'b1;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt <= CW'(TIMEOUT-1);
`endif
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
`ifdef ARB_TIMEOUT_EN
                    end else if (tmo_cnt == '0) begin
                        state       <= IDLE;
                        arb_busy    <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
`endif
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

`ifndef ARB_TIMEOUT_EN
    // Without the watchdog TIMEOUT has no effect; the flag is constant 0.
    assign timeout_err = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: scoreboard of expected (id, byte) issues plus a simple TX busy model.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  slot_full;
    logic [7:0]  tx_p_data;
    logic        tx_data_valid;
    logic        tx_busy;
    logic [1:0]  cur_id;
    logic        arb_busy;
    logic        timeout_err;

    typedef struct {logic [1:0] id; logic [7:0] data;} frame_t;
    frame_t exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int n_issued = 0;
    int busy_len = 3;
    bit model_en = 1'b1;
    logic prev_arb;

    uart_tx_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .slot_full(slot_full), .tx_p_data(tx_p_data),
        .tx_data_valid(tx_data_valid), .tx_busy(tx_busy), .cur_id(cur_id),
        .arb_busy(arb_busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic expect_frame(input logic [1:0] id, input logic [7:0] data);
        frame_t f;
        f.id   = id;
        f.data = data;
        exp_q.push_back(f);
    endtask

    // Drive an offer for one edge, then withdraw it.
    task automatic offer(input logic [3:0] mask, input logic [31:0] bytes);
        req_valid = mask;
        req_data  = bytes;
        @(posedge clk); #1;
        req_valid = '0;
    endtask

    task automatic hold_until_ack(input int i, input int budget);
        int n = 0;
        while (req_ack[i] !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("held_offer_ack", req_ack[i], 1'b1);
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_issue(input int target, input int budget);
        int n = 0;
        while (n_issued < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_issue_in_time", n < budget, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((arb_busy || slot_full != 4'd0 || tx_busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_idle_in_time", n < budget, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // TX model: busy rises one edge after DATA_VALID and stays up busy_len cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_data_valid === 1'b1 && model_en) begin
                @(posedge clk); #1 tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Scoreboard: every issue pulse must match the next expected frame.
    initial begin
        frame_t e;
        prev_arb = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_data_valid === 1'b1) begin
                n_issued++;
                check("valid_while_busy", tx_busy, 1'b0);
                check("idle_cycle_before_issue", prev_arb, 1'b0);
                check("issue_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("issue_id", cur_id, e.id);
                    check("issue_data", tx_p_data, e.data);
                end
            end
            prev_arb = arb_busy;
        end
    end

    initial begin
        int base;
        int cnt;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_req_ack", req_ack, 4'd0);
        check("rst_slot_full", slot_full, 4'd0);
        check("rst_tx_p_data", tx_p_data, 8'd0);
        check("rst_tx_valid", tx_data_valid, 1'b0);
        check("rst_cur_id", cur_id, 2'd0);
        check("rst_arb_busy", arb_busy, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single request, latency
        expect_frame(2'd2, 8'hF9);
        offer(4'b0100, 32'h00F9_0000);
        check("t1_ack", req_ack, 4'b0100);
        check("t1_full", slot_full, 4'b0100);
        check("t1_no_valid_yet", tx_data_valid, 1'b0);
        @(posedge clk); #1;
        check("t1_ack_drop", req_ack, 4'b0000);
        check("t1_valid", tx_data_valid, 1'b1);
        check("t1_cur_id", cur_id, 2'd2);
        check("t1_data", tx_p_data, 8'hF9);
        check("t1_arb_busy", arb_busy, 1'b1);
        @(posedge clk); #1;
        check("t1_slot_cleared", slot_full, 4'b0000);
        check("t1_valid_pulse", tx_data_valid, 1'b0);
        @(posedge clk); #1;
        check("t1_arb_busy_wait", arb_busy, 1'b1);
        wait_idle(100);

        // 2: round robin from fresh reset, then reload 0 and 3 after id 1
        do_reset();
        @(posedge clk); #1;
        base = n_issued;
        expect_frame(2'd0, 8'h85);
        expect_frame(2'd1, 8'h40);
        expect_frame(2'd2, 8'hF2);
        expect_frame(2'd3, 8'h3C);
        offer(4'b1111, 32'h3CF2_4085);
        check("t2_ack_all", req_ack, 4'b1111);
        check("t2_full_all", slot_full, 4'b1111);
        wait_issue(base + 2, 200);
        expect_frame(2'd0, 8'hA0);
        expect_frame(2'd3, 8'hA3);
        req_valid = 4'b1001;
        req_data  = 32'hA300_00A0;
        @(posedge clk); #1;
        check("t2_reload0_ack", req_ack, 4'b0001);
        req_valid[0] = 1'b0;
        hold_until_ack(3, 200);
        wait_idle(300);
        check("t2_frame_count", n_issued - base, 6);

        // 3: offer into a full slot is held off until it frees
        base = n_issued;
        expect_frame(2'd1, 8'h11);
        expect_frame(2'd1, 8'h22);
        offer(4'b0010, 32'h0000_1100);
        check("t3_first_ack", req_ack, 4'b0010);
        req_valid = 4'b0010;
        req_data  = 32'h0000_2200;
        @(posedge clk); #1;
        check("t3_issue", tx_data_valid, 1'b1);
        check("t3_no_ack_full", req_ack, 4'b0000);
        @(posedge clk); #1;
        check("t3_no_ack_clear_edge", req_ack, 4'b0000);
        @(posedge clk); #1;
        check("t3_ack_after_free", req_ack, 4'b0010);
        check("t3_refilled", slot_full, 4'b0010);
        req_valid = '0;
        wait_idle(200);
        check("t3_frame_count", n_issued - base, 2);

        // 4: long busy frames, two pending slots (pointer sits at 2)
        busy_len = 11;
        base = n_issued;
        expect_frame(2'd2, 8'hA5);
        expect_frame(2'd1, 8'h5A);
        offer(4'b0110, 32'h00A5_5A00);
        wait_idle(300);
        check("t4_frame_count", n_issued - base, 2);

        // 5: reset during WAIT_DONE with slot 3 still full
        base = n_issued;
        expect_frame(2'd2, 8'h77);
        offer(4'b1100, 32'h3377_0000);
        wait_issue(base + 1, 100);
        repeat (4) @(posedge clk); #1;
        check("t5_tx_busy_up", tx_busy, 1'b1);
        check("t5_slot3_pending", slot_full, 4'b1000);
        #2 rst = 1'b1;
        #1;
        check("t5_async_full", slot_full, 4'd0);
        check("t5_async_arb_busy", arb_busy, 1'b0);
        check("t5_async_cur_id", cur_id, 2'd0);
        check("t5_async_data", tx_p_data, 8'd0);
        check("t5_async_valid", tx_data_valid, 1'b0);
        check("t5_async_ack", req_ack, 4'd0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (20) @(posedge clk); #1;
        check("t5_no_reissue", n_issued - base, 1);
        check("t5_slots_empty", slot_full, 4'd0);
        busy_len = 3;
        expect_frame(2'd0, 8'h10);
        expect_frame(2'd3, 8'h13);
        offer(4'b1001, 32'h1300_0010);
        wait_idle(200);
        check("t5_frame_count", n_issued - base, 3);

`ifdef ARB_TIMEOUT_EN
        // 6: TX never raises busy
        model_en = 1'b0;
        expect_frame(2'd0, 8'hE1);
        expect_frame(2'd1, 8'hE2);
        offer(4'b0011, 32'h0000_E2E1);
        @(posedge clk); #1;
        check("t6_issue", tx_data_valid, 1'b1);
        cnt = 0;
        do begin
            @(posedge clk); #1;
            if (arb_busy) cnt++;
        end while (arb_busy && cnt < 100);
        check("t6_wait_busy_cycles", cnt, 15);
        check("t6_timeout_err", timeout_err, 1'b1);
        wait_idle(200);
        check("t6_err_sticky", timeout_err, 1'b1);
        model_en = 1'b1;
        expect_frame(2'd2, 8'h99);
        offer(4'b0100, 32'h0099_0000);
        wait_idle(200);
        check("t6_err_sticky_after_ok", timeout_err, 1'b1);
`else
        check("no_watchdog_err", timeout_err, 1'b0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
